// File: rtl/vga_pkg.sv
// Shared types and default 800x600@72Hz timing (50 MHz pixel clock) for the VGA scanout path.
package vga_pkg;

    typedef logic [2:0][3:0] color_t;

    localparam int BEAM_X_W      = 11;
    localparam int BEAM_Y_W      = 10;
    localparam int LAYER_LATENCY = 1;

    localparam int VGA_H_VISIBLE = 800;
    localparam int VGA_H_FRONT   = 56;
    localparam int VGA_H_SYNC    = 120;
    localparam int VGA_H_BACK    = 64;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 600;
    localparam int VGA_V_FRONT   = 37;
    localparam int VGA_V_SYNC    = 6;
    localparam int VGA_V_BACK    = 23;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

endpackage

// File: rtl/vga_timing.sv
// Beam counters plus the stage-0 decode of display-enable, hsync and vsync.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic                clk,
    input  logic                rst,
    output logic [BEAM_X_W-1:0] beam_x,
    output logic [BEAM_Y_W-1:0] beam_y,
    output logic                frame_start,
    output logic                in_vblank,
    output logic                de,
    output logic                hs,
    output logic                vs
);

    localparam logic [BEAM_X_W-1:0] X_LAST   = BEAM_X_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [BEAM_X_W-1:0] X_VIS    = BEAM_X_W'(H_VISIBLE);
    localparam logic [BEAM_X_W-1:0] HS_START = BEAM_X_W'(H_VISIBLE + H_FRONT);
    localparam logic [BEAM_X_W-1:0] HS_END   = BEAM_X_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [BEAM_Y_W-1:0] Y_LAST   = BEAM_Y_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [BEAM_Y_W-1:0] Y_VIS    = BEAM_Y_W'(V_VISIBLE);
    localparam logic [BEAM_Y_W-1:0] VS_START = BEAM_Y_W'(V_VISIBLE + V_FRONT);
    localparam logic [BEAM_Y_W-1:0] VS_END   = BEAM_Y_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic                x_wrap;
    logic                y_wrap;
    logic [BEAM_X_W-1:0] next_x;
    logic [BEAM_Y_W-1:0] next_y;

    always_comb begin
        x_wrap = (beam_x == X_LAST);
        y_wrap = (beam_y == Y_LAST);
        next_x = x_wrap ? '0 : beam_x + 1'b1;
        next_y = beam_y;
        if (x_wrap) begin
            next_y = y_wrap ? '0 : beam_y + 1'b1;
        end
    end

    // frame_start/in_vblank are computed from the next beam so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            beam_x      <= '0;
            beam_y      <= '0;
            frame_start <= 1'b0;
            in_vblank   <= 1'b0;
        end else begin
            beam_x      <= next_x;
            beam_y      <= next_y;
            frame_start <= x_wrap && y_wrap;
            in_vblank   <= (next_y >= Y_VIS);
        end
    end

    assign de = (beam_x < X_VIS) && (beam_y < Y_VIS);
    assign hs = (beam_x >= HS_START) && (beam_x < HS_END);
    assign vs = (beam_y >= VS_START) && (beam_y < VS_END);

endmodule

// File: rtl/vga_scanout_compositor.sv
// Beam generator, layer priority resolution and latency-matched sync/blanking for the VGA pins.
module vga_scanout_compositor
    import vga_pkg::*;
#(
    parameter int   NUM_LAYERS   = 4,
    parameter int   H_VISIBLE    = VGA_H_VISIBLE,
    parameter int   H_FRONT      = VGA_H_FRONT,
    parameter int   H_SYNC       = VGA_H_SYNC,
    parameter int   H_BACK       = VGA_H_BACK,
    parameter int   V_VISIBLE    = VGA_V_VISIBLE,
    parameter int   V_FRONT      = VGA_V_FRONT,
    parameter int   V_SYNC       = VGA_V_SYNC,
    parameter int   V_BACK       = VGA_V_BACK,
    parameter logic HSYNC_ACTIVE = 1'b1,
    parameter logic VSYNC_ACTIVE = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [BEAM_X_W-1:0]              beam_x,
    output logic [BEAM_Y_W-1:0]              beam_y,
    input  logic [NUM_LAYERS-1:0][2:0][3:0]  layer_color,
    input  logic [NUM_LAYERS-1:0]            layer_transparent,
    input  logic [2:0][3:0]                  bg_color,
    output logic [2:0][3:0]                  vga_rgb,
    output logic                             vga_hsync,
    output logic                             vga_vsync,
    output logic                             frame_start,
    output logic                             in_vblank
);

    logic       de;
    logic       hs;
    logic       vs;
    logic [2:0] ctl_pipe [LAYER_LATENCY];
    logic       de_d;
    logic       hs_d;
    logic       vs_d;
    color_t     pixel;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .beam_x      (beam_x),
        .beam_y      (beam_y),
        .frame_start (frame_start),
        .in_vblank   (in_vblank),
        .de          (de),
        .hs          (hs),
        .vs          (vs)
    );

    // Controls wait here while the renderers fetch the pixel for the same beam.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAYER_LATENCY; i++) begin
                ctl_pipe[i] <= '0;
            end
        end else begin
            ctl_pipe[0] <= {de, hs, vs};
            for (int i = 1; i < LAYER_LATENCY; i++) begin
                ctl_pipe[i] <= ctl_pipe[i-1];
            end
        end
    end

    assign {de_d, hs_d, vs_d} = ctl_pipe[LAYER_LATENCY-1];

    // Walk from lowest to highest priority so the lowest opaque index wins.
    always_comb begin
        pixel = bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (!layer_transparent[i]) begin
                pixel = layer_color[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_rgb   <= '0;
            vga_hsync <= ~HSYNC_ACTIVE;
            vga_vsync <= ~VSYNC_ACTIVE;
        end else begin
            vga_rgb   <= de_d ? pixel : '0;
            vga_hsync <= hs_d ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
            vga_vsync <= vs_d ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
        end
    end

endmodule
